cpu7_ifu_fctl: RTL and testbench

Fetch controller that sequences the instruction-cache port for the IFU front end. It owns the fetch PC and issues one 64-bit line request at a time, tracking it through the ack and data phases. It buffers the returned two-instruction line and hands instructions one per cycle to the decoder under stall back-pressure. It applies redirects (exception, ertn, branch) and cancels stale in-flight requests.

---
 rtl/cpu7_ifu_fctl.sv | 197 +++++++++++++++++++
 tb/tb_cpu7_ifu_fctl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_fctl.sv
// Fetch controller for the IFU front end.
// Owns the fetch PC and keeps at most one 64-bit line request in flight
// to the instruction cache. It buffers the returned two-instruction line
// and hands out one instruction per cycle under decoder stall. Redirects
// retarget the fetch PC and cancel any accepted request that is now stale.
module cpu7_ifu_fctl (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] pc_init,
    input  logic        exu_ifu_except,
    input  logic [31:0] exu_ifu_eentry,
    input  logic        exu_ifu_ertn_e,
    input  logic [31:0] exu_ifu_era,
    input  logic        exu_ifu_br_taken,
    input  logic [31:0] exu_ifu_br_target,
    output logic        ifu_icu_req_ic1,
    output logic [31:0] ifu_icu_addr_ic1,
    input  logic        icu_ifu_ack_ic1,
    output logic        ifu_icu_cancel,
    input  logic [63:0] icu_ifu_data_ic2,
    input  logic        icu_ifu_data_valid_ic2,
    output logic        fctl_dec_vld_d,
    output logic [31:0] fctl_dec_inst_d,
    output logic [31:0] fctl_dec_pc_d,
    input  logic        exu_ifu_stall_req
);

    // IDLE: one cycle after reset to load the boot PC.
    // REQ : request presented, waiting for the icache to accept it.
    // WAIT: request accepted, waiting for line data.
    // BUF : line held locally, instructions handed to the decoder.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_BUF  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic        lo_vld_q;
    logic        lo_vld_d;
    logic        hi_vld_q;
    logic        hi_vld_d;

    // Buffered line and the aligned address it was fetched from.
    logic [63:0] line_buf;
    logic [31:0] buf_base;
    logic        line_we;

    // Last instruction/PC presented with valid, so the decoder-facing
    // outputs stay put while nothing new is being offered.
    logic [31:0] held_inst;
    logic [31:0] held_pc;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] line_base;
    logic [31:0] shown_inst;
    logic [31:0] shown_pc;
    logic        consume;
    logic        in_req;
    logic        in_wait;
    logic        in_buf;

    assign in_req  = (state_q == S_REQ);
    assign in_wait = (state_q == S_WAIT);
    assign in_buf  = (state_q == S_BUF);

    assign redirect = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;

    // Redirect target: exception beats ertn beats branch; word-aligned.
    always_comb begin
        target_raw = exu_ifu_br_target;
        if (exu_ifu_ertn_e) begin
            target_raw = exu_ifu_era;
        end
        if (exu_ifu_except) begin
            target_raw = exu_ifu_eentry;
        end
    end

    assign target    = target_raw & 32'hFFFF_FFFC;
    assign line_base = fetch_pc_q & 32'hFFFF_FFF8;

    // The low slot is always offered first; once it is gone, the high one.
    assign shown_inst = lo_vld_q ? line_buf[31:0] : line_buf[63:32];
    assign shown_pc   = lo_vld_q ? buf_base : (buf_base + 32'd4);

    assign ifu_icu_req_ic1  = in_req;
    assign ifu_icu_addr_ic1 = line_base;

    // A request is only killable once the icache has accepted it: either
    // in the very cycle of the ack, or any time while waiting for data.
    assign ifu_icu_cancel = redirect & ((in_req & icu_ifu_ack_ic1) | in_wait);

    assign fctl_dec_vld_d  = in_buf & (lo_vld_q | hi_vld_q) & ~redirect;
    assign fctl_dec_inst_d = fctl_dec_vld_d ? shown_inst : held_inst;
    assign fctl_dec_pc_d   = fctl_dec_vld_d ? shown_pc : held_pc;

    assign consume = fctl_dec_vld_d & ~exu_ifu_stall_req;

    // Next-state, fetch PC and buffer-slot bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        lo_vld_d   = lo_vld_q;
        hi_vld_d   = hi_vld_q;
        line_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Redirects are deliberately ignored here: boot PC wins.
                fetch_pc_d = pc_init & 32'hFFFF_FFFC;
                state_d    = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    // Stay in REQ so the new address goes out next cycle.
                    fetch_pc_d = target;
                end else if (icu_ifu_ack_ic1) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // Data arriving alongside the redirect is stale.
                    fetch_pc_d = target;
                    state_d    = S_REQ;
                end else if (icu_ifu_data_valid_ic2) begin
                    line_we    = 1'b1;
                    lo_vld_d   = ~fetch_pc_q[2];
                    hi_vld_d   = 1'b1;
                    fetch_pc_d = line_base + 32'd8;
                    state_d    = S_BUF;
                end
            end
            S_BUF: begin
                if (redirect) begin
                    // Nothing is outstanding, so no cancel is needed.
                    lo_vld_d   = 1'b0;
                    hi_vld_d   = 1'b0;
                    fetch_pc_d = target;
                    state_d    = S_REQ;
                end else if (consume) begin
                    if (lo_vld_q) begin
                        lo_vld_d = 1'b0;
                        if (!hi_vld_q) begin
                            state_d = S_REQ;
                        end
                    end else begin
                        hi_vld_d = 1'b0;
                        state_d  = S_REQ;
                    end
                end else if (!lo_vld_q && !hi_vld_q) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, fetch PC and held decoder outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= 32'd0;
            lo_vld_q   <= 1'b0;
            hi_vld_q   <= 1'b0;
            held_inst  <= 32'd0;
            held_pc    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            lo_vld_q   <= lo_vld_d;
            hi_vld_q   <= hi_vld_d;
            if (fctl_dec_vld_d) begin
                held_inst <= shown_inst;
                held_pc   <= shown_pc;
            end
        end
    end

    // Line buffer: qualified by the slot valids, so it needs no reset.
    always_ff @(posedge clock) begin
        if (line_we) begin
            line_buf <= icu_ifu_data_ic2;
            buf_base <= line_base;
        end
    end

endmodule

// File: tb/tb_cpu7_ifu_fctl.sv
// Bench for cpu7_ifu_fctl: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_cpu7_ifu_fctl;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] pc_init;
    logic        exu_ifu_except;
    logic [31:0] exu_ifu_eentry;
    logic        exu_ifu_ertn_e;
    logic [31:0] exu_ifu_era;
    logic        exu_ifu_br_taken;
    logic [31:0] exu_ifu_br_target;
    logic        ifu_icu_req_ic1;
    logic [31:0] ifu_icu_addr_ic1;
    logic        icu_ifu_ack_ic1;
    logic        ifu_icu_cancel;
    logic [63:0] icu_ifu_data_ic2;
    logic        icu_ifu_data_valid_ic2;
    logic        fctl_dec_vld_d;
    logic [31:0] fctl_dec_inst_d;
    logic [31:0] fctl_dec_pc_d;
    logic        exu_ifu_stall_req;

    int checks = 0;
    int errors = 0;

    cpu7_ifu_fctl dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .pc_init                (pc_init),
        .exu_ifu_except         (exu_ifu_except),
        .exu_ifu_eentry         (exu_ifu_eentry),
        .exu_ifu_ertn_e         (exu_ifu_ertn_e),
        .exu_ifu_era            (exu_ifu_era),
        .exu_ifu_br_taken       (exu_ifu_br_taken),
        .exu_ifu_br_target      (exu_ifu_br_target),
        .ifu_icu_req_ic1        (ifu_icu_req_ic1),
        .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
        .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
        .ifu_icu_cancel         (ifu_icu_cancel),
        .icu_ifu_data_ic2       (icu_ifu_data_ic2),
        .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
        .fctl_dec_vld_d         (fctl_dec_vld_d),
        .fctl_dec_inst_d        (fctl_dec_inst_d),
        .fctl_dec_pc_d          (fctl_dec_pc_d),
        .exu_ifu_stall_req      (exu_ifu_stall_req)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [31:0] rpc;
        logic        ack;
        logic        dv;
        logic [63:0] data;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_cancel;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } slot_t;

    vec_t tbl[$];

    // Reference model: a fetch in flight is just "awaiting", a delivered
    // line becomes a queue of instructions for the decoder.
    bit          m_boot;
    bit          m_awaiting;
    slot_t       m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_last_inst;
    logic [31:0] m_last_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [31:0] rpc,
                                input logic ack, input logic dv, input logic [63:0] data,
                                input logic br, input logic [31:0] tgt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_cancel, input logic e_vld,
                                input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rpc = rpc; v.ack = ack; v.dv = dv; v.data = data;
        v.br = br; v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr;
        v.e_cancel = e_cancel; v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic clear_inputs();
        exu_ifu_except         = 1'b0;
        exu_ifu_eentry         = 32'd0;
        exu_ifu_ertn_e         = 1'b0;
        exu_ifu_era            = 32'd0;
        exu_ifu_br_taken       = 1'b0;
        exu_ifu_br_target      = 32'd0;
        icu_ifu_ack_ic1        = 1'b0;
        icu_ifu_data_ic2       = 64'd0;
        icu_ifu_data_valid_ic2 = 1'b0;
        exu_ifu_stall_req      = 1'b0;
    endtask

    // Ends at a falling edge with reset released: the IDLE cycle follows.
    task automatic apply_reset(input logic [31:0] pc);
        @(negedge clock);
        clear_inputs();
        resetn = 1'b0;
        #1;
        chk("rst_req", ifu_icu_req_ic1, 1'b0);
        chk("rst_cancel", ifu_icu_cancel, 1'b0);
        chk("rst_vld", fctl_dec_vld_d, 1'b0);
        chk("rst_inst", fctl_dec_inst_d, 32'd0);
        chk("rst_pc", fctl_dec_pc_d, 32'd0);
        chk("rst_addr", ifu_icu_addr_ic1, 32'd0);
        @(negedge clock);
        resetn  = 1'b1;
        pc_init = pc;
        m_boot      = 1'b1;
        m_awaiting  = 1'b0;
        m_q.delete();
        m_pc        = 32'd0;
        m_last_inst = 32'd0;
        m_last_pc   = 32'd0;
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic model_cycle();
        logic        r;
        logic [31:0] tgt;
        logic [31:0] base;
        logic        e_req;
        logic        e_cancel;
        logic        e_vld;
        slot_t       s;
        r = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;
        tgt = exu_ifu_except ? exu_ifu_eentry :
              exu_ifu_ertn_e ? exu_ifu_era : exu_ifu_br_target;
        tgt = tgt & ~32'h3;
        e_req = 1'b0; e_cancel = 1'b0; e_vld = 1'b0;
        base = m_pc & ~32'h7;
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = pc_init & ~32'h3;
        end else if (m_q.size() > 0) begin
            e_vld = !r;
            if (e_vld) begin
                m_last_inst = m_q[0].inst;
                m_last_pc   = m_q[0].pc;
            end
            if (r) begin
                m_q.delete();
                m_pc = tgt;
            end else if (!exu_ifu_stall_req) begin
                void'(m_q.pop_front());
            end
        end else if (m_awaiting) begin
            e_cancel = r;
            if (r) begin
                m_pc = tgt;
                m_awaiting = 1'b0;
            end else if (icu_ifu_data_valid_ic2) begin
                if (!m_pc[2]) begin
                    s.inst = icu_ifu_data_ic2[31:0];
                    s.pc   = base;
                    m_q.push_back(s);
                end
                s.inst = icu_ifu_data_ic2[63:32];
                s.pc   = base + 32'd4;
                m_q.push_back(s);
                m_pc = base + 32'd8;
                m_awaiting = 1'b0;
            end
        end else begin
            e_req    = 1'b1;
            e_cancel = r & icu_ifu_ack_ic1;
            chk("rnd_addr", ifu_icu_addr_ic1, base);
            if (r) begin
                m_pc = tgt;
            end else if (icu_ifu_ack_ic1) begin
                m_awaiting = 1'b1;
            end
        end
        chk("rnd_req", ifu_icu_req_ic1, e_req);
        chk("rnd_cancel", ifu_icu_cancel, e_cancel);
        chk("rnd_vld", fctl_dec_vld_d, e_vld);
        chk("rnd_inst", fctl_dec_inst_d, m_last_inst);
        chk("rnd_pc", fctl_dec_pc_d, m_last_pc);
    endtask

    initial begin
        resetn  = 1'b0;
        pc_init = 32'd0;
        clear_inputs();

        // Directed table: basic aligned line, misaligned start, redirects in WAIT/REQ.
        tbl.push_back(mk(1, 32'h1C000000, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 1, 0, 64'd0, 0, 0, 1, 32'h1C000000, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h22222222_11111111, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 32'h11111111, 32'h1C000000));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 32'h22222222, 32'h1C000004));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 1, 32'h1C000008, 0, 0, 32'h22222222, 32'h1C000004));
        tbl.push_back(mk(1, 32'h1C000004, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 1, 0, 64'd0, 0, 0, 1, 32'h1C000000, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 0, 1, 64'hBBBBBBBB_AAAAAAAA, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 32'hBBBBBBBB, 32'h1C000004));
        tbl.push_back(mk(0, 0, 1, 0, 64'd0, 0, 0, 1, 32'h1C000008, 0, 0, 32'hBBBBBBBB, 32'h1C000004));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB, 32'h1C000004));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 1, 32'h1C000302, 0, 0, 1, 0, 32'hBBBBBBBB, 32'h1C000004));
        tbl.push_back(mk(0, 0, 1, 0, 64'd0, 1, 32'h1C000400, 1, 32'h1C000300, 1, 0, 32'hBBBBBBBB, 32'h1C000004));
        tbl.push_back(mk(0, 0, 0, 0, 64'd0, 0, 0, 1, 32'h1C000400, 0, 0, 32'hBBBBBBBB, 32'h1C000004));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) apply_reset(tbl[i].rpc);
            clear_inputs();
            icu_ifu_ack_ic1        = tbl[i].ack;
            icu_ifu_data_valid_ic2 = tbl[i].dv;
            icu_ifu_data_ic2       = tbl[i].data;
            exu_ifu_br_taken       = tbl[i].br;
            exu_ifu_br_target      = tbl[i].tgt;
            #1;
            chk($sformatf("tbl%0d_req", i), ifu_icu_req_ic1, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), ifu_icu_addr_ic1, tbl[i].e_addr);
            chk($sformatf("tbl%0d_cancel", i), ifu_icu_cancel, tbl[i].e_cancel);
            chk($sformatf("tbl%0d_vld", i), fctl_dec_vld_d, tbl[i].e_vld);
            chk($sformatf("tbl%0d_inst", i), fctl_dec_inst_d, tbl[i].e_inst);
            chk($sformatf("tbl%0d_pc", i), fctl_dec_pc_d, tbl[i].e_pc);
            cyc();
        end

        // Branch in WAIT together with data_valid.
        apply_reset(32'h1C000000);
        cyc();
        icu_ifu_ack_ic1 = 1'b1;
        cyc();
        clear_inputs();
        exu_ifu_br_taken = 1'b1; exu_ifu_br_target = 32'h1C000100;
        icu_ifu_data_valid_ic2 = 1'b1; icu_ifu_data_ic2 = 64'hDEADBEEF_CAFEF00D;
        #1;
        chk("bw_cancel", ifu_icu_cancel, 1'b1);
        chk("bw_vld", fctl_dec_vld_d, 1'b0);
        cyc();
        clear_inputs();
        #1;
        chk("bw_cancel_drop", ifu_icu_cancel, 1'b0);
        chk("bw_req", ifu_icu_req_ic1, 1'b1);
        chk("bw_addr", ifu_icu_addr_ic1, 32'h1C000100);
        chk("bw_vld_next", fctl_dec_vld_d, 1'b0);
        cyc();
        #1;
        chk("bw_vld_later", fctl_dec_vld_d, 1'b0);
        chk("bw_req_later", ifu_icu_req_ic1, 1'b1);

        // Exception and branch together while in BUF.
        apply_reset(32'h1C000000);
        cyc();
        icu_ifu_ack_ic1 = 1'b1;
        cyc();
        clear_inputs();
        icu_ifu_data_valid_ic2 = 1'b1; icu_ifu_data_ic2 = 64'h12345678_9ABCDEF0;
        cyc();
        clear_inputs();
        exu_ifu_except = 1'b1; exu_ifu_eentry = 32'h1C008000;
        exu_ifu_br_taken = 1'b1; exu_ifu_br_target = 32'h1C000200;
        #1;
        chk("sr_vld", fctl_dec_vld_d, 1'b0);
        chk("sr_cancel", ifu_icu_cancel, 1'b0);
        chk("sr_req", ifu_icu_req_ic1, 1'b0);
        cyc();
        clear_inputs();
        #1;
        chk("sr_req_next", ifu_icu_req_ic1, 1'b1);
        chk("sr_addr_next", ifu_icu_addr_ic1, 32'h1C008000);
        chk("sr_vld_next", fctl_dec_vld_d, 1'b0);

        // Stall holds the low slot, then lo and hi on consecutive cycles.
        apply_reset(32'h1C000000);
        cyc();
        icu_ifu_ack_ic1 = 1'b1;
        cyc();
        clear_inputs();
        icu_ifu_data_valid_ic2 = 1'b1; icu_ifu_data_ic2 = 64'h44444444_33333333;
        cyc();
        clear_inputs();
        exu_ifu_stall_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st%0d_vld", k), fctl_dec_vld_d, 1'b1);
            chk($sformatf("st%0d_inst", k), fctl_dec_inst_d, 32'h33333333);
            chk($sformatf("st%0d_pc", k), fctl_dec_pc_d, 32'h1C000000);
            chk($sformatf("st%0d_req", k), ifu_icu_req_ic1, 1'b0);
            cyc();
        end
        exu_ifu_stall_req = 1'b0;
        #1;
        chk("st_lo_inst", fctl_dec_inst_d, 32'h33333333);
        chk("st_lo_vld", fctl_dec_vld_d, 1'b1);
        cyc();
        #1;
        chk("st_hi_vld", fctl_dec_vld_d, 1'b1);
        chk("st_hi_inst", fctl_dec_inst_d, 32'h44444444);
        chk("st_hi_pc", fctl_dec_pc_d, 32'h1C000004);
        cyc();
        #1;
        chk("st_next_req", ifu_icu_req_ic1, 1'b1);
        chk("st_next_addr", ifu_icu_addr_ic1, 32'h1C000008);
        chk("st_next_vld", fctl_dec_vld_d, 1'b0);

        // Asynchronous reset while WAIT is cancelling, then a stray data_valid in IDLE.
        apply_reset(32'h1C000000);
        cyc();
        icu_ifu_ack_ic1 = 1'b1;
        cyc();
        clear_inputs();
        exu_ifu_br_taken = 1'b1; exu_ifu_br_target = 32'h1C000500;
        #1;
        chk("ar_cancel_before", ifu_icu_cancel, 1'b1);
        resetn = 1'b0;
        #1;
        chk("ar_cancel", ifu_icu_cancel, 1'b0);
        chk("ar_req", ifu_icu_req_ic1, 1'b0);
        chk("ar_vld", fctl_dec_vld_d, 1'b0);
        cyc();
        clear_inputs();
        resetn = 1'b1;
        pc_init = 32'h1C000040;
        icu_ifu_data_valid_ic2 = 1'b1; icu_ifu_data_ic2 = 64'h66666666_55555555;
        #1;
        chk("ar_idle_req", ifu_icu_req_ic1, 1'b0);
        chk("ar_idle_vld", fctl_dec_vld_d, 1'b0);
        cyc();
        clear_inputs();
        #1;
        chk("ar_req_after", ifu_icu_req_ic1, 1'b1);
        chk("ar_addr_after", ifu_icu_addr_ic1, 32'h1C000040);
        chk("ar_vld_after", fctl_dec_vld_d, 1'b0);
        icu_ifu_ack_ic1 = 1'b1;
        cyc();
        clear_inputs();
        #1;
        chk("ar_wait_vld", fctl_dec_vld_d, 1'b0);
        chk("ar_wait_req", ifu_icu_req_ic1, 1'b0);
        icu_ifu_data_valid_ic2 = 1'b1; icu_ifu_data_ic2 = 64'h88888888_77777777;
        cyc();
        clear_inputs();
        #1;
        chk("ar_buf_vld", fctl_dec_vld_d, 1'b1);
        chk("ar_buf_inst", fctl_dec_inst_d, 32'h77777777);
        chk("ar_buf_pc", fctl_dec_pc_d, 32'h1C000040);

        // Randomized traffic against the reference model.
        for (int blk = 0; blk < 3; blk++) begin
            apply_reset($urandom);
            for (int n = 0; n < 1500; n++) begin
                pc_init                = $urandom;
                icu_ifu_ack_ic1        = 1'($urandom_range(0, 1));
                icu_ifu_data_valid_ic2 = (($urandom % 5) < 2);
                icu_ifu_data_ic2       = {$urandom, $urandom};
                exu_ifu_stall_req      = (($urandom % 10) < 3);
                exu_ifu_except         = (($urandom % 24) == 0);
                exu_ifu_ertn_e         = (($urandom % 24) == 0);
                exu_ifu_br_taken       = (($urandom % 12) == 0);
                exu_ifu_eentry         = $urandom;
                exu_ifu_era            = $urandom;
                exu_ifu_br_target      = (blk == 2) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                #1;
                model_cycle();
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
